// File: rtl/tmds_frame_decoder.sv
// tmds_frame_decoder: decodes three TMDS channels to RGB/DE/sync, tracks pixel position, frame geometry, lock and symbol errors
module tmds_frame_decoder #(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 11,
  parameter bit VSYNC_POL = 1'b1,
  parameter int ERR_BITS  = 16
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [9:0]          tmds_r,
  input  logic [9:0]          tmds_g,
  input  logic [9:0]          tmds_b,
  output logic                de,
  output logic                hsync,
  output logic                vsync,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic [X_BITS-1:0]   pixel_x,
  output logic [Y_BITS-1:0]   pixel_y,
  output logic                frame_start,
  output logic [X_BITS-1:0]   line_length,
  output logic [Y_BITS-1:0]   frame_lines,
  output logic                locked,
  output logic                code_error,
  output logic [ERR_BITS-1:0] err_count
);
  localparam logic [1:0] SEARCH = 2'd0, MEASURE = 2'd1, LOCK = 2'd2;
  // {is_control, c1, c0}
  function automatic logic [2:0] ctl(input logic [9:0] s);
    return s == 10'b1101010100 ? 3'b100 :
           s == 10'b0010101011 ? 3'b101 :
           s == 10'b0101010100 ? 3'b110 :
           s == 10'b1010101011 ? 3'b111 : 3'b000;
  endfunction
  function automatic logic [7:0] dec(input logic [9:0] q);
    logic [7:0] v, d;
    v = q[9] ? ~q[7:0] : q[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? v[i] ^ v[i-1] : ~(v[i] ^ v[i-1]);
    return d;
  endfunction
  logic [9:0] s_r, s_g, s_b;
  logic [2:0] cr, cg, cb;
  logic [1:0] state, nxt;
  logic de_n, err_n, vs_edge, de_fall, de_rise, fs_n, line_bad, mis_n, wrap_n, ferr_n, good;
  logic vs_seen, have_first, mismatch, frame_err, wrap;
  logic [X_BITS-1:0] first_len, line_cnt, ref_len;
  logic [Y_BITS-1:0] cur_lines;
  always_comb begin
    cr = ctl(s_r);
    cg = ctl(s_g);
    cb = ctl(s_b);
    de_n = !cb[2];
    err_n = cb[2] ? !(cr[2] && cg[2]) : (cr[2] || cg[2]);
    vs_edge = cb[2] && (cb[1] == VSYNC_POL) && (vsync != VSYNC_POL);
    de_fall = de && !de_n;
    de_rise = de_n && !de;
    fs_n = de_rise && vs_seen && pixel_y == '0;
    line_cnt = pixel_x + 1'b1;
    cur_lines = de_fall ? pixel_y + 1'b1 : pixel_y;
    ref_len = state == LOCK ? line_length : first_len;
    line_bad = de_fall && (state == LOCK || have_first) && line_cnt != ref_len;
    mis_n = mismatch || line_bad;
    wrap_n = wrap || (de_n && de && &pixel_x) || (de_fall && &pixel_y);
    ferr_n = frame_err || err_n;
    good = cur_lines != '0 && !mis_n && !ferr_n && !wrap_n;
    // an error or counter wrap while locked drops lock immediately; everything else is judged at VSYNC
    nxt = (state == LOCK && (err_n || wrap_n)) ? SEARCH :
          !vs_edge ? state :
          err_n ? SEARCH :
          state == SEARCH ? MEASURE :
          (good && (state == MEASURE || cur_lines == frame_lines)) ? LOCK :
          state == MEASURE ? MEASURE : SEARCH;
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      {s_r, s_g, s_b} <= '0;
      {de, hsync, vsync, red, green, blue} <= '0;
      {pixel_x, pixel_y, frame_start, line_length, frame_lines} <= '0;
      {locked, code_error, err_count, state} <= '0;
      {vs_seen, have_first, mismatch, frame_err, wrap, first_len} <= '0;
    end else begin
      s_r <= tmds_r;
      s_g <= tmds_g;
      s_b <= tmds_b;
      de <= de_n;
      code_error <= err_n;
      if (de_n) {red, green, blue} <= {dec(s_r), dec(s_g), dec(s_b)};
      else {vsync, hsync} <= cb[1:0];
      err_count <= err_count + {{(ERR_BITS-1){1'b0}}, err_n && !(&err_count)};
      pixel_x <= de_rise ? '0 : de_n ? line_cnt : pixel_x;
      pixel_y <= vs_edge ? '0 : de_fall ? pixel_y + 1'b1 : pixel_y;
      vs_seen <= vs_edge ? 1'b1 : fs_n ? 1'b0 : vs_seen;
      frame_start <= fs_n;
      mismatch <= vs_edge ? 1'b0 : mis_n;
      frame_err <= vs_edge ? 1'b0 : ferr_n;
      wrap <= vs_edge ? 1'b0 : wrap_n;
      have_first <= vs_edge ? 1'b0 : have_first || de_fall;
      if (de_fall && !have_first) first_len <= line_cnt;
      if (vs_edge && state == MEASURE && nxt == LOCK) begin
        line_length <= have_first ? first_len : line_cnt;
        frame_lines <= cur_lines;
      end
      state <= nxt;
      locked <= nxt == LOCK;
    end
  end
endmodule
